// File: rtl/binary_dense_layer_seq.sv
// Sequential binary-input fully connected layer: streams weights from a synchronous memory,
// evaluates one neuron after another with saturating accumulation, optional ReLU and argmax.
module binary_dense_layer_seq #(
    parameter int unsigned IN_DIM    = 784,
    parameter int unsigned OUT_DIM   = 10,
    parameter int unsigned W_WIDTH   = 8,
    parameter int unsigned ACC_WIDTH = 24,
    parameter int unsigned RELU      = 1,
    parameter int unsigned AW        = $clog2(OUT_DIM * (IN_DIM + 1)),
    parameter int unsigned IDX_W     = $clog2(OUT_DIM)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [IN_DIM-1:0]            image_in,
    output logic                         busy,
    output logic                         weight_re,
    output logic [AW-1:0]                weight_addr,
    input  logic [W_WIDTH-1:0]           weight_data,
    output logic [OUT_DIM*ACC_WIDTH-1:0] out_vec,
    output logic [IDX_W-1:0]             argmax_idx,
    output logic                         valid
);

    localparam int unsigned CW = $clog2(IN_DIM + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [AW-1:0]    LAST_ADDR = AW'(OUT_DIM * (IN_DIM + 1) - 1);
    localparam logic [CW-1:0]    BIAS_POS  = CW'(IN_DIM);
    localparam logic [IDX_W-1:0] LAST_NEU  = IDX_W'(OUT_DIM - 1);

    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH - 1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH - 1){1'b0}}};

    logic [1:0]                  state;
    logic [IN_DIM-1:0]           img;
    logic [CW-1:0]               in_cnt;
    logic [IDX_W-1:0]            neu_cnt;

    // Tag of the read whose data is on weight_data this cycle.
    logic                        d_valid;
    logic                        d_bias;
    logic [IDX_W-1:0]            d_neu;

    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] best;
    logic [ACC_WIDTH-1:0]        res [OUT_DIM];

    logic signed [ACC_WIDTH-1:0] term;
    logic signed [ACC_WIDTH:0]   wide;
    logic signed [ACC_WIDTH-1:0] sum;
    logic signed [ACC_WIDTH-1:0] act;

    always_comb begin
        term = '0;
        // img is rotated so that the current input's bit always sits in the MSB.
        if (d_bias || img[IN_DIM-1]) begin
            term = ACC_WIDTH'($signed(weight_data));
        end
        wide = {acc[ACC_WIDTH-1], acc} + {term[ACC_WIDTH-1], term};
        if (wide[ACC_WIDTH] != wide[ACC_WIDTH-1]) begin
            sum = wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end else begin
            sum = wide[ACC_WIDTH-1:0];
        end
        act = ((RELU != 0) && sum[ACC_WIDTH-1]) ? '0 : sum;
    end

    assign busy = (state != S_IDLE) || valid;

    for (genvar j = 0; j < OUT_DIM; j++) begin : g_out
        assign out_vec[j*ACC_WIDTH +: ACC_WIDTH] = res[j];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            img         <= '0;
            in_cnt      <= '0;
            neu_cnt     <= '0;
            d_valid     <= 1'b0;
            d_bias      <= 1'b0;
            d_neu       <= '0;
            acc         <= '0;
            best        <= '0;
            weight_re   <= 1'b0;
            weight_addr <= '0;
            argmax_idx  <= '0;
            valid       <= 1'b0;
            for (int j = 0; j < OUT_DIM; j++) begin
                res[j] <= '0;
            end
        end else begin
            valid   <= 1'b0;
            d_valid <= 1'b0;

            case (state)
                S_IDLE: begin
                    // A start arriving during the valid cycle is still part of the old run.
                    if (start && !valid) begin
                        state       <= S_RUN;
                        img         <= image_in;
                        weight_re   <= 1'b1;
                        weight_addr <= '0;
                        in_cnt      <= '0;
                        neu_cnt     <= '0;
                        acc         <= '0;
                    end
                end
                S_RUN: begin
                    d_valid <= 1'b1;
                    d_bias  <= (in_cnt == BIAS_POS);
                    d_neu   <= neu_cnt;
                    if (in_cnt == BIAS_POS) begin
                        in_cnt  <= '0;
                        neu_cnt <= neu_cnt + 1'b1;
                    end else begin
                        in_cnt <= in_cnt + 1'b1;
                    end
                    if (weight_addr == LAST_ADDR) begin
                        weight_re <= 1'b0;
                        state     <= S_DRAIN;
                    end else begin
                        weight_addr <= weight_addr + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (d_valid && d_bias && (d_neu == LAST_NEU)) begin
                        state <= S_IDLE;
                        valid <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (d_valid) begin
                if (d_bias) begin
                    acc        <= '0;
                    res[d_neu] <= act;
                    if ((d_neu == '0) || (act > best)) begin
                        best       <= act;
                        argmax_idx <= d_neu;
                    end
                end else begin
                    acc <= sum;
                    img <= {img[IN_DIM-2:0], img[IN_DIM-1]};
                end
            end
        end
    end

endmodule

// File: tb/tb_binary_dense_layer_seq.sv
// Directed bench: three small layer configurations sharing one start line plus the default
// 784->10 layer, each fed from its own behavioural synchronous weight memory.
module tb_binary_dense_layer_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [3:0] img4 = 4'b1010;
    logic [3:0] img_c = 4'b1111;

    always #5 clk = ~clk;

    logic        busy_a, re_a, valid_a, busy_b, re_b, valid_b, busy_c, re_c, valid_c;
    logic [3:0]  addr_a, addr_b, addr_c;
    logic [7:0]  wd_a, wd_b, wd_c;
    logic [35:0] out_a, out_b;
    logic [23:0] out_c;
    logic [1:0]  idx_a, idx_b, idx_c;

    logic         start_d = 1'b0;
    logic [783:0] img_d = '0;
    logic         busy_d, re_d, valid_d;
    logic [12:0]  addr_d;
    logic [7:0]   wd_d;
    logic [239:0] out_d;
    logic [3:0]   idx_d;

    logic [7:0] mem_ab [15];
    logic [7:0] mem_c  [15];
    logic [7:0] mem_d  [7850];

    always_ff @(posedge clk) begin
        if (re_a) wd_a <= mem_ab[addr_a];
        if (re_b) wd_b <= mem_ab[addr_b];
        if (re_c) wd_c <= mem_c[addr_c];
        if (re_d) wd_d <= mem_d[addr_d];
    end

    binary_dense_layer_seq #(.IN_DIM(4), .OUT_DIM(3), .W_WIDTH(8), .ACC_WIDTH(12), .RELU(1)) u_a (
        .clk(clk), .rst(rst), .start(start), .image_in(img4), .busy(busy_a),
        .weight_re(re_a), .weight_addr(addr_a), .weight_data(wd_a), .out_vec(out_a),
        .argmax_idx(idx_a), .valid(valid_a)
    );

    binary_dense_layer_seq #(.IN_DIM(4), .OUT_DIM(3), .W_WIDTH(8), .ACC_WIDTH(12), .RELU(0)) u_b (
        .clk(clk), .rst(rst), .start(start), .image_in(img4), .busy(busy_b),
        .weight_re(re_b), .weight_addr(addr_b), .weight_data(wd_b), .out_vec(out_b),
        .argmax_idx(idx_b), .valid(valid_b)
    );

    binary_dense_layer_seq #(.IN_DIM(4), .OUT_DIM(3), .W_WIDTH(8), .ACC_WIDTH(8), .RELU(0)) u_c (
        .clk(clk), .rst(rst), .start(start), .image_in(img_c), .busy(busy_c),
        .weight_re(re_c), .weight_addr(addr_c), .weight_data(wd_c), .out_vec(out_c),
        .argmax_idx(idx_c), .valid(valid_c)
    );

    binary_dense_layer_seq u_d (
        .clk(clk), .rst(rst), .start(start_d), .image_in(img_d), .busy(busy_d),
        .weight_re(re_d), .weight_addr(addr_d), .weight_data(wd_d), .out_vec(out_d),
        .argmax_idx(idx_d), .valid(valid_d)
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint slot12(input logic [35:0] v, input int j);
        logic signed [11:0] s;
        s = v[j*12 +: 12];
        return longint'(s);
    endfunction

    function automatic longint slot8(input logic [23:0] v, input int j);
        logic signed [7:0] s;
        s = v[j*8 +: 8];
        return longint'(s);
    endfunction

    function automatic longint slot24(input logic [239:0] v, input int j);
        logic signed [23:0] s;
        s = v[j*24 +: 24];
        return longint'(s);
    endfunction

    // Launches one run of the small layers; optional extra start pulses and a mid-run reset,
    // all timed in cycles after the accepting edge.
    task automatic run_small(input int xp1, input int xp2, input int rst_at,
                             output int lat, output int lat_b, output int nv,
                             output int sweep_bad, output int re_after);
        lat = -1; lat_b = -1; nv = 0; sweep_bad = 0; re_after = -1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) begin
                @(negedge clk);
                start = 1'b0;
                img4 = 4'b1010;
            end
            if (rst_at < 0) begin
                if (k <= 14) begin
                    if (!(re_a === 1'b1 && int'(addr_a) == k)) sweep_bad++;
                end else if (re_a !== 1'b0) begin
                    sweep_bad++;
                end
            end
            if (valid_a === 1'b1) begin
                nv++;
                if (lat < 0) lat = k;
            end
            if (valid_b === 1'b1 && lat_b < 0) lat_b = k;
            if (rst_at >= 0 && k == rst_at + 1) begin
                re_after = int'(re_a);
                rst = 1'b0;
            end
            if (k == rst_at) rst = 1'b1;
            if (k == xp1 || k == xp2) begin
                start = 1'b1;
                img4 = 4'b1111;
            end
        end
    endtask

    int basic_w [15] = '{5, -3, 7, 1, -2, -10, 4, -1, 0, 3, 2, 2, 2, 2, 6};
    int sat2_w  [15] = '{-128, -128, -128, -128, -128, -128, -128, -128, -128, -128,
                         127, 127, -128, 5, 0};

    initial begin
        int lat, lat_b, nv, sweep_bad, re_after, lat_d;

        for (int i = 0; i < 15; i++) begin
            mem_ab[i] = 8'(basic_w[i]);
            mem_c[i]  = 8'h7f;
        end
        for (int i = 0; i < 7850; i++) begin
            if (i % 785 == 784) mem_d[i] = 8'((i / 785) * 3 - 9);
            else mem_d[i] = 8'($urandom);
        end

        // Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", busy_a, 0);
        check("rst_valid", valid_a, 0);
        check("rst_re", re_a, 0);
        check("rst_addr", addr_a, 0);
        check("rst_out", out_a, 0);
        check("rst_idx", idx_a, 0);
        check("rst_out_d", out_d, 0);
        repeat (3) @(negedge clk);
        check("hold_busy", busy_a, 0);
        check("hold_re_d", re_d, 0);
        check("hold_out", out_a, 0);

        // Basic run: RELU on/off, saturation to +max in parallel
        run_small(-1, -1, -1, lat, lat_b, nv, sweep_bad, re_after);
        check("basic_latency", lat, 16);
        check("basic_nvalid", nv, 1);
        check("basic_sweep", sweep_bad, 0);
        check("basic_out0", slot12(out_a, 0), 10);
        check("basic_out1", slot12(out_a, 1), 0);
        check("basic_out2", slot12(out_a, 2), 10);
        check("basic_idx", idx_a, 0);
        check("norelu_latency", lat_b, 16);
        check("norelu_out0", slot12(out_b, 0), 10);
        check("norelu_out1", slot12(out_b, 1), -8);
        check("norelu_out2", slot12(out_b, 2), 10);
        check("norelu_idx", idx_b, 0);
        check("satpos_out0", slot8(out_c, 0), 127);
        check("satpos_out1", slot8(out_c, 1), 127);
        check("satpos_out2", slot8(out_c, 2), 127);
        check("satpos_idx", idx_c, 0);
        check("idle_busy", busy_a, 0);

        // Ignored extra starts (with corrupted image), saturation to -min and no wrap
        for (int i = 0; i < 15; i++) mem_c[i] = 8'(sat2_w[i]);
        run_small(3, 16, -1, lat, lat_b, nv, sweep_bad, re_after);
        check("extra_nvalid", nv, 1);
        check("extra_latency", lat, 16);
        check("extra_out0", slot12(out_a, 0), 10);
        check("extra_out1", slot12(out_a, 1), 0);
        check("extra_out2", slot12(out_a, 2), 10);
        check("extra_busy", busy_a, 0);
        check("satneg_out0", slot8(out_c, 0), -128);
        check("satneg_out1", slot8(out_c, 1), -128);
        check("nowrap_out2", slot8(out_c, 2), 4);
        check("satneg_idx", idx_c, 2);

        // Abort by reset mid-run, then a clean run
        run_small(-1, -1, 7, lat, lat_b, nv, sweep_bad, re_after);
        check("abort_re", re_after, 0);
        check("abort_nvalid", nv, 0);
        check("abort_busy", busy_a, 0);
        check("abort_out_cleared", slot12(out_a, 0), 0);
        run_small(-1, -1, -1, lat, lat_b, nv, sweep_bad, re_after);
        check("rerun_latency", lat, 16);
        check("rerun_out0", slot12(out_a, 0), 10);
        check("rerun_out1", slot12(out_a, 1), 0);
        check("rerun_out2", slot12(out_a, 2), 10);
        check("rerun_idx", idx_a, 0);

        // Default 784->10, blank image: outputs are ReLU'd biases
        lat_d = -1;
        @(negedge clk);
        start_d = 1'b1;
        @(negedge clk);
        start_d = 1'b0;
        for (int k = 0; k < 8000 && lat_d < 0; k++) begin
            if (k > 0) @(negedge clk);
            if (valid_d === 1'b1) lat_d = k;
        end
        check("dflt_latency", lat_d, 7851);
        check("dflt_out0", slot24(out_d, 0), 0);
        check("dflt_out3", slot24(out_d, 3), 0);
        check("dflt_out4", slot24(out_d, 4), 3);
        check("dflt_out5", slot24(out_d, 5), 6);
        check("dflt_out9", slot24(out_d, 9), 18);
        check("dflt_idx", idx_d, 9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
